gowin_pll_phase_ctrl: RTL and testbench

- Multi-channel dynamic phase/duty controller for the Gowin rPLL PSDA/DUTYDA inputs.
- Replaces single-edge, single-PLL phase stepping with a request/ready handshake, multi-step bursts, a per-step settle timer, wrap or saturate modes, and lock-loss abort.
- Sits between the DDR calibration logic and the pll_ddr* instances; one channel per PLL with dynamic phase.

---
 rtl/gowin_ddr_pkg.sv | 74 +++++++
 rtl/gowin_pll_phase_chan.sv | 51 +++++
 rtl/gowin_pll_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_gowin_pll_phase_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gowin_ddr_pkg.sv
// Shared definitions for the Gowin rPLL dynamic phase/duty control path.
//   - state_t      : phase controller FSM states
//   - phase_t      : default-width phase code (PSDA/DUTYDA encoding)
//   - PHASE_0DEG / DUTY_50PCT : encodings for 0 degrees and 50% duty
//   - phase_step() : one phase step with wrap or saturate, returns {phase, sat}
package gowin_ddr_pkg;

  localparam int PHASE_W_DEF = 4;
  // Wide enough for any supported phase width; callers pass the real width.
  localparam int PHASE_MAX_W = 16;

  typedef logic [PHASE_W_DEF-1:0] phase_t;
  typedef logic [PHASE_MAX_W-1:0] phase_wide_t;

  localparam phase_t PHASE_0DEG = '0;
  // Duty code equal to half the phase range gives a 50% duty cycle.
  localparam phase_t DUTY_50PCT = phase_t'(1 << (PHASE_W_DEF - 1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_DONE
  } state_t;

  typedef struct packed {
    phase_wide_t phase;
    logic        sat;
  } step_res_t;

  // One step of size 'step' in direction 'up' on a 'width'-bit phase.
  // wrap=1: modulo 2^width. wrap=0: clamp at 0 / 2^width-1 and flag sat
  // whenever the step would pass a bound (landing exactly on it is fine).
  function automatic step_res_t phase_step(input phase_wide_t phase,
                                           input logic        up,
                                           input phase_wide_t step,
                                           input logic        wrap,
                                           input int unsigned width);
    logic [PHASE_MAX_W:0] one;
    logic [PHASE_MAX_W:0] max_val;
    logic [PHASE_MAX_W:0] sum;
    step_res_t            res;
    one     = 1;
    max_val = (one << width) - one;
    res.sat = 1'b0;
    if (up) begin
      sum = {1'b0, phase} + {1'b0, step};
      if (sum > max_val) begin
        if (wrap) begin
          res.phase = sum[PHASE_MAX_W-1:0] & max_val[PHASE_MAX_W-1:0];
        end else begin
          res.phase = max_val[PHASE_MAX_W-1:0];
          res.sat   = 1'b1;
        end
      end else begin
        res.phase = sum[PHASE_MAX_W-1:0];
      end
    end else begin
      sum = '0;
      if (step > phase) begin
        if (wrap) begin
          res.phase = (phase - step) & max_val[PHASE_MAX_W-1:0];
        end else begin
          res.phase = '0;
          res.sat   = 1'b1;
        end
      end else begin
        res.phase = phase - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gowin_pll_phase_chan.sv
// Per-PLL phase/duty register pair.
//   clk, rst (async active-low)
//   step_en : apply one step this cycle
//   up      : step direction
//   psda    : current phase code
//   dutyda  : duty code, always psda + DUTY_OFFSET
//   sat     : the step that would be applied now saturates (WRAP=0 only)
module gowin_pll_phase_chan
  import gowin_ddr_pkg::*;
#(
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int STEP        = 2,
  parameter int DUTY_OFFSET = 8,
  parameter int WRAP        = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic               up,
  output logic [PHASE_W-1:0] psda,
  output logic [PHASE_W-1:0] dutyda,
  output logic               sat
);

  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] duty_reg;
  logic [PHASE_W-1:0] phase_next;
  step_res_t          res;

  always_comb begin
    res        = phase_step(phase_wide_t'(phase_reg), up, phase_wide_t'(STEP),
                            WRAP != 0, PHASE_W);
    phase_next = PHASE_W'(res.phase);
    sat        = res.sat;
  end

  // Duty is derived from the new (possibly clamped) phase on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= '0;
      duty_reg  <= PHASE_W'(DUTY_OFFSET);
    end else if (step_en) begin
      phase_reg <= phase_next;
      duty_reg  <= phase_next + PHASE_W'(DUTY_OFFSET);
    end
  end

  assign psda   = phase_reg;
  assign dutyda = duty_reg;

endmodule

// File: rtl/gowin_pll_phase_ctrl.sv
// Multi-channel dynamic phase/duty controller for Gowin rPLL PSDA/DUTYDA.
//   clk, rst (async active-low)
//   req_valid/req_ready/req_chan/req_up/req_steps : burst request handshake
//   pll_locked : per-PLL lock; loss on the active channel aborts the burst
//   psda/dutyda: per-channel codes, channel 0 in the LSBs
//   busy       : STEP..DONE; done: 1-cycle end pulse with err_sat/err_lock
module gowin_pll_phase_ctrl
  import gowin_ddr_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int STEP          = 2,
  parameter int DUTY_OFFSET   = int'(DUTY_50PCT),
  parameter int SETTLE_CYCLES = 8,
  parameter int WRAP          = 1,
  localparam int CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SET_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [CHAN_W-1:0]           req_chan,
  input  logic                        req_up,
  input  logic [3:0]                  req_steps,
  input  logic [CHANNELS-1:0]         pll_locked,
  output logic [CHANNELS*PHASE_W-1:0] psda,
  output logic [CHANNELS*PHASE_W-1:0] dutyda,
  output logic                        busy,
  output logic                        done,
  output logic                        err_sat,
  output logic                        err_lock
);

  state_t              state_reg, state_next;
  logic [CHAN_W-1:0]   chan_reg, chan_next;
  logic                up_reg, up_next;
  logic [3:0]          steps_reg, steps_next;
  logic [SET_W-1:0]    settle_reg, settle_next;
  logic                err_sat_reg, err_sat_next;
  logic                err_lock_reg, err_lock_next;

  logic [CHANNELS-1:0] chan_onehot;
  logic [CHANNELS-1:0] step_en;
  logic [CHANNELS-1:0] sat_vec;
  logic                sat_sel;
  logic                locked_sel;
  logic                req_chan_valid;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_onehot[gi] = (int'(chan_reg) == gi);
      assign step_en[gi]     = (state_reg == ST_STEP) && chan_onehot[gi];

      gowin_pll_phase_chan #(
        .PHASE_W     (PHASE_W),
        .STEP        (STEP),
        .DUTY_OFFSET (DUTY_OFFSET),
        .WRAP        (WRAP)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en[gi]),
        .up      (up_reg),
        .psda    (psda[gi*PHASE_W +: PHASE_W]),
        .dutyda  (dutyda[gi*PHASE_W +: PHASE_W]),
        .sat     (sat_vec[gi])
      );
    end
  endgenerate

  // Only the active channel's lock and saturation matter.
  assign sat_sel        = |(sat_vec & chan_onehot);
  assign locked_sel     = |(pll_locked & chan_onehot);
  assign req_chan_valid = (int'(req_chan) < CHANNELS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      chan_reg     <= '0;
      up_reg       <= 1'b0;
      steps_reg    <= '0;
      settle_reg   <= '0;
      err_sat_reg  <= 1'b0;
      err_lock_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      chan_reg     <= chan_next;
      up_reg       <= up_next;
      steps_reg    <= steps_next;
      settle_reg   <= settle_next;
      err_sat_reg  <= err_sat_next;
      err_lock_reg <= err_lock_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    chan_next     = chan_reg;
    up_next       = up_reg;
    steps_next    = steps_reg;
    settle_next   = settle_reg;
    err_sat_next  = err_sat_reg;
    err_lock_next = err_lock_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          chan_next     = req_chan;
          up_next       = req_up;
          steps_next    = req_steps;
          err_sat_next  = 1'b0;
          err_lock_next = 1'b0;
          // Zero-length bursts and nonexistent channels finish as no-ops.
          state_next    = (req_steps == 4'd0 || !req_chan_valid) ? ST_DONE : ST_STEP;
        end
      end
      ST_STEP: begin
        // The channel register applies the step on this edge regardless.
        steps_next  = steps_reg - 4'd1;
        settle_next = SET_W'(SETTLE_CYCLES - 1);
        state_next  = ST_SETTLE;
        if (sat_sel) begin
          err_sat_next = 1'b1;
          state_next   = ST_DONE;
        end
        if (!locked_sel) begin
          err_lock_next = 1'b1;
          state_next    = ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (!locked_sel) begin
          err_lock_next = 1'b1;
          state_next    = ST_DONE;
        end else if (settle_reg == '0) begin
          state_next = (steps_reg != 4'd0) ? ST_STEP : ST_DONE;
        end else begin
          settle_next = settle_reg - SET_W'(1);
        end
      end
      ST_DONE: begin
        err_sat_next  = 1'b0;
        err_lock_next = 1'b0;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err_sat   = done && err_sat_reg;
  assign err_lock  = done && err_lock_reg;

endmodule

// File: tb/tb_gowin_pll_phase_ctrl.sv
// Bench for gowin_pll_phase_ctrl. Two instances share all inputs: dut_a wraps,
// dut_b saturates. A burst-level model predicts, for every cycle after the
// handshake, each channel's phase/duty and the handshake/status outputs.
module tb_gowin_pll_phase_ctrl;

  localparam int CH  = 3;
  localparam int PW  = 4;
  localparam int ST  = 2;
  localparam int OFF = 8;
  localparam int SC  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic [1:0]      req_chan;
  logic            req_up;
  logic [3:0]      req_steps;
  logic [CH-1:0]   pll_locked;

  logic            a_ready, a_busy, a_done, a_err_sat, a_err_lock;
  logic [CH*PW-1:0] a_psda, a_dutyda;
  logic            b_ready, b_busy, b_done, b_err_sat, b_err_lock;
  logic [CH*PW-1:0] b_psda, b_dutyda;

  int cmp_count  = 0;
  int fail_count = 0;
  int mph[2][CH];

  always #5 clk = ~clk;

  gowin_pll_phase_ctrl #(.CHANNELS(CH), .PHASE_W(PW), .STEP(ST), .DUTY_OFFSET(OFF),
                         .SETTLE_CYCLES(SC), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
    .req_chan(req_chan), .req_up(req_up), .req_steps(req_steps),
    .pll_locked(pll_locked), .psda(a_psda), .dutyda(a_dutyda), .busy(a_busy),
    .done(a_done), .err_sat(a_err_sat), .err_lock(a_err_lock));

  gowin_pll_phase_ctrl #(.CHANNELS(CH), .PHASE_W(PW), .STEP(ST), .DUTY_OFFSET(OFF),
                         .SETTLE_CYCLES(SC), .WRAP(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
    .req_chan(req_chan), .req_up(req_up), .req_steps(req_steps),
    .pll_locked(pll_locked), .psda(b_psda), .dutyda(b_dutyda), .busy(b_busy),
    .done(b_done), .err_sat(b_err_sat), .err_lock(b_err_lock));

  task automatic wait_both_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_ready && b_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      cmp_count++;
      fail_count++;
      $display("FAIL ready_timeout: ready a=%b b=%b, required 1 1", a_ready, b_ready);
    end
  endtask

  // One burst: model both instances, handshake, then compare every cycle
  // until both are back in IDLE. lock_at>0 drops pll_locked[lock_chan] so
  // that it is low at handshake-edge + lock_at and afterwards.
  task automatic run_burst(input int chan, input bit up, input int steps,
                           input int lock_chan, input int lock_at, input bit hold);
    int  ph[2][16];
    int  napp[2];
    int  done_off[2];
    bit  es[2];
    bit  el[2];
    int  maxd;
    int  p;
    int  lk;
    bit  ended;
    bit  ok;
    lk = (lock_chan == chan) ? lock_at : 0;
    for (int d = 0; d < 2; d++) begin
      napp[d] = 0; es[d] = 0; el[d] = 0; done_off[d] = 0; ended = 0;
      ph[d][0] = (chan < CH) ? mph[d][chan] : 0;
      if (chan < CH && steps > 0) begin
        p = ph[d][0];
        for (int k = 1; k <= steps; k++) begin
          int stk;
          stk = 1 + (k - 1) * (SC + 1);
          if (lk > 0 && lk < stk) begin
            done_off[d] = lk; el[d] = 1; ended = 1;
            break;
          end
          p = up ? p + ST : p - ST;
          if (d == 0) p = (p + 16) % 16;
          else if (p > 15) begin p = 15; es[d] = 1; end
          else if (p < 0) begin p = 0; es[d] = 1; end
          ph[d][k] = p;
          napp[d] = k;
          if (lk == stk) el[d] = 1;
          if (es[d] || lk == stk) begin
            done_off[d] = stk; ended = 1;
            break;
          end
        end
        if (!ended) begin
          if (lk > 0 && lk <= steps * (SC + 1)) begin
            done_off[d] = lk; el[d] = 1;
          end else begin
            done_off[d] = steps * (SC + 1);
          end
        end
      end
    end
    maxd = (done_off[0] > done_off[1]) ? done_off[0] : done_off[1];

    wait_both_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_chan  = 2'(chan);
    req_up    = up;
    req_steps = 4'(steps);

    for (int o = 0; o <= maxd + 1; o++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic [CH*PW-1:0] ep, ed, op, od;
        logic [4:0]       es_v, os_v;
        int               a;
        a = 0;
        for (int k = 1; k <= napp[d]; k++)
          if (1 + (k - 1) * (SC + 1) <= o) a = k;
        for (int c = 0; c < CH; c++) begin
          int v;
          v = (c == chan && a > 0) ? ph[d][a] : mph[d][c];
          ep[c*PW +: PW] = 4'(v);
          ed[c*PW +: PW] = 4'((v + OFF) % 16);
        end
        es_v = {o > done_off[d], o <= done_off[d], o == done_off[d],
                (o == done_off[d]) && es[d], (o == done_off[d]) && el[d]};
        op   = d ? b_psda : a_psda;
        od   = d ? b_dutyda : a_dutyda;
        os_v = d ? {b_ready, b_busy, b_done, b_err_sat, b_err_lock}
                 : {a_ready, a_busy, a_done, a_err_sat, a_err_lock};
        cmp_count += 3;
        if (op !== ep) begin
          fail_count++;
          $display("FAIL psda dut%0d off%0d: got %h, required %h", d, o, op, ep);
        end
        if (od !== ed) begin
          fail_count++;
          $display("FAIL dutyda dut%0d off%0d: got %h, required %h", d, o, od, ed);
        end
        if (os_v !== es_v) begin
          fail_count++;
          $display("FAIL status{rdy,busy,done,sat,lock} dut%0d off%0d: got %b, required %b",
                   d, o, os_v, es_v);
        end
      end
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (lock_at > 0 && o + 1 == lock_at) pll_locked[lock_chan] = 1'b0;
    end
    req_valid  = 1'b0;
    pll_locked = '1;
    if (chan < CH) begin
      mph[0][chan] = ph[0][napp[0]];
      mph[1][chan] = ph[1][napp[1]];
    end
    $display("burst chan=%0d up=%0d steps=%0d lock=%0d@%0d: done_off a=%0d b=%0d sat b=%0d lock a=%0d",
             chan, up, steps, lock_chan, lock_at, done_off[0], done_off[1], es[1], el[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [CH*PW-1:0] exp_duty;
    exp_duty = {CH{4'(OFF)}};
    cmp_count += 4;
    if ({a_psda, b_psda} !== '0) begin
      fail_count++;
      $display("FAIL %s psda: got %h %h, required 000 000", tag, a_psda, b_psda);
    end
    if (a_dutyda !== exp_duty || b_dutyda !== exp_duty) begin
      fail_count++;
      $display("FAIL %s dutyda: got %h %h, required %h", tag, a_dutyda, b_dutyda, exp_duty);
    end
    if ({a_ready, b_ready} !== 2'b11) begin
      fail_count++;
      $display("FAIL %s req_ready: got %b%b, required 11", tag, a_ready, b_ready);
    end
    if ({a_busy, a_done, a_err_sat, a_err_lock, b_busy, b_done, b_err_sat, b_err_lock} !== '0) begin
      fail_count++;
      $display("FAIL %s flags: got %b%b%b%b %b%b%b%b, required all 0", tag,
               a_busy, a_done, a_err_sat, a_err_lock, b_busy, b_done, b_err_sat, b_err_lock);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 0; req_chan = 0; req_up = 0; req_steps = 0; pll_locked = '1;
    #12;
    check_reset_outputs("reset_active");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset_idle");
    end
    for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) mph[d][c] = 0;
  endtask

  task automatic test_basic_up();
    run_burst(1, 1'b1, 3, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst(0, 1'b0, 1, 0, 0, 1'b0);   // a: 0 -> 14, b: clamps at 0
    run_burst(0, 1'b1, 2, 0, 0, 1'b0);   // a: 14 -> 0 -> 2
  endtask

  task automatic test_saturate();
    run_burst(0, 1'b1, 4, 0, 0, 1'b0);   // b reaches 12
    run_burst(0, 1'b1, 4, 0, 0, 1'b0);   // b: 14 then clamped 15
  endtask

  task automatic test_lock_loss();
    // Drop lock mid-SETTLE of step 1 with req_valid held the whole time.
    run_burst(1, 1'b1, 4, 1, 5, 1'b1);
    // Lock loss on another channel is ignored.
    run_burst(2, 1'b1, 2, 0, 3, 1'b0);
  endtask

  task automatic test_zero_and_invalid();
    run_burst(1, 1'b1, 0, 0, 0, 1'b0);
    run_burst(3, 1'b1, 5, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      int lc, la;
      lc = 0; la = 0;
      if ($urandom_range(0, 3) == 0) begin
        lc = $urandom_range(0, CH - 1);
        la = $urandom_range(1, 60);
      end
      run_burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                lc, la, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_both_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_chan = 2'd0; req_up = 1'b1; req_steps = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) mph[d][c] = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("after_async_reset");
    run_burst(2, 1'b0, 2, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap();
    test_saturate();
    test_lock_loss();
    test_zero_and_invalid();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
